fxp_var_shifter_pipe: RTL

//  Pipelined, parametrised signed fixed-point barrel shifter: out = in * 2^shift, shift signed
//  (+ left, - arithmetic right). Successor to the 64b combinational shifter. Adds:
//   - valid/ready streaming and configurable pipeline registers
//   - optional round-half-up on right shifts
//   - optional saturation with an overflow flag on left shifts
//   - a pass-through tag

---
 rtl/fxp_var_shifter_pipe_pkg.sv | 25 ++
 rtl/fxp_shift_stage.sv | 35 +++
 rtl/fxp_var_shifter_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fxp_var_shifter_pipe_pkg.sv
// Shared types and defaults for the pipelined signed fixed-point barrel shifter.
// Holds the shift-direction encoding and the control word that travels with each beat.
package fxp_var_shifter_pipe_pkg;

    localparam int FXP_WIDTH_DEF = 64;
    localparam int FXP_SHW_DEF   = 8;
    localparam int FXP_TAGW_DEF  = 4;

    typedef enum logic {
        SH_LEFT  = 1'b0,
        SH_RIGHT = 1'b1
    } shift_dir_e;

    // oor: |shift| >= WIDTH, handled by the bypass in the final stage.
    // xsign/xnz describe the original operand; ovf/guard accumulate across mux levels.
    typedef struct packed {
        shift_dir_e dir;
        logic       oor;
        logic       xsign;
        logic       xnz;
        logic       ovf;
        logic       guard;
    } shift_ctl_t;

endpackage

// File: rtl/fxp_shift_stage.sv
// One barrel-shifter mux level: shifts by 2^K when enabled, in the direction carried in ctl.
// Left shifts accumulate overflow; right shifts record the most recent bit shifted out.
module fxp_shift_stage
    import fxp_var_shifter_pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int K     = 0
) (
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] data_i,
    input  shift_ctl_t       ctl_i,
    output logic [WIDTH-1:0] data_o,
    output shift_ctl_t       ctl_o
);

    localparam int S = 1 << K;

    always_comb begin
        data_o = data_i;
        ctl_o  = ctl_i;
        if (shift_en_i) begin
            if (ctl_i.dir == SH_LEFT) begin
                data_o = data_i << S;
                // Bits leaving the word plus the new MSB must all be copies of the sign.
                if (data_i[WIDTH-1 -: S+1] != {(S+1){ctl_i.xsign}}) begin
                    ctl_o.ovf = 1'b1;
                end
            end else begin
                data_o      = $signed(data_i) >>> S;
                ctl_o.guard = data_i[S-1];
            end
        end
    end

endmodule

// File: rtl/fxp_var_shifter_pipe.sv
// Pipelined signed barrel shifter: out = in * 2^shift with optional rounding and saturation.
// Valid/ready streaming; a register follows mux level k when PIPE_MASK[k] is set.
module fxp_var_shifter_pipe
    import fxp_var_shifter_pipe_pkg::*;
#(
    parameter int          WIDTH     = FXP_WIDTH_DEF,
    parameter int          SHW       = FXP_SHW_DEF,
    parameter int          TAGW      = FXP_TAGW_DEF,
    parameter logic [31:0] PIPE_MASK = 32'd0,
    parameter bit          RND_EN    = 1'b0,
    parameter bit          SAT_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic [TAGW-1:0]  out_tag
);

    localparam int LVL = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Valid/ready: a beat moves across a boundary when valid & ready are both high on a clock
    // edge; a register loads whenever it is empty or its own beat leaves in the same cycle.
    logic             lv_valid [0:LVL];
    logic             lv_ready [0:LVL];
    logic [WIDTH-1:0] lv_data  [0:LVL];
    shift_ctl_t       lv_ctl   [0:LVL];
    logic [TAGW-1:0]  lv_tag   [0:LVL];
    logic [LVL-1:0]   lv_n     [0:LVL-1];

    // Magnitude at SHW+1 bits so that the most negative shift is represented exactly.
    logic [SHW:0] sh_ext;
    logic [SHW:0] n_full;

    always_comb begin
        sh_ext = {in_shift[SHW-1], in_shift};
        n_full = sh_ext[SHW] ? ((~sh_ext) + (SHW+1)'(1)) : sh_ext;
    end

    always_comb begin
        lv_ctl[0]       = '0;
        lv_ctl[0].dir   = in_shift[SHW-1] ? SH_RIGHT : SH_LEFT;
        lv_ctl[0].oor   = (32'(n_full) >= 32'(WIDTH));
        lv_ctl[0].xsign = in_data[WIDTH-1];
        lv_ctl[0].xnz   = |in_data;
    end

    assign lv_valid[0] = in_valid;
    assign lv_data[0]  = in_data;
    assign lv_tag[0]   = in_tag;
    assign lv_n[0]     = n_full[LVL-1:0];
    assign in_ready    = lv_ready[0];

    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        logic [WIDTH-1:0] st_data;
        shift_ctl_t       st_ctl;

        fxp_shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .shift_en_i (lv_n[k][k]),
            .data_i     (lv_data[k]),
            .ctl_i      (lv_ctl[k]),
            .data_o     (st_data),
            .ctl_o      (st_ctl)
        );

        if (PIPE_MASK[k]) begin : g_reg
            logic             vld_q;
            logic [WIDTH-1:0] data_q;
            shift_ctl_t       ctl_q;
            logic [TAGW-1:0]  tag_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                    ctl_q  <= '0;
                    tag_q  <= '0;
                end else if (lv_ready[k]) begin
                    vld_q <= lv_valid[k];
                    if (lv_valid[k]) begin
                        data_q <= st_data;
                        ctl_q  <= st_ctl;
                        tag_q  <= lv_tag[k];
                    end
                end
            end

            assign lv_ready[k]   = ~vld_q | lv_ready[k+1];
            assign lv_valid[k+1] = vld_q;
            assign lv_data[k+1]  = data_q;
            assign lv_ctl[k+1]   = ctl_q;
            assign lv_tag[k+1]   = tag_q;
        end else begin : g_comb
            assign lv_ready[k]   = lv_ready[k+1];
            assign lv_valid[k+1] = lv_valid[k];
            assign lv_data[k+1]  = st_data;
            assign lv_ctl[k+1]   = st_ctl;
            assign lv_tag[k+1]   = lv_tag[k];
        end

        // Only later levels need the shift amount.
        if (k < LVL-1) begin : g_n
            if (PIPE_MASK[k]) begin : g_nreg
                logic [LVL-1:0] n_q;
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        n_q <= '0;
                    end else if (lv_ready[k] && lv_valid[k]) begin
                        n_q <= lv_n[k];
                    end
                end
                assign lv_n[k+1] = n_q;
            end else begin : g_npass
                assign lv_n[k+1] = lv_n[k];
            end
        end
    end

    // Final stage: out-of-range bypass, rounding and saturation.
    shift_ctl_t       fin_ctl;
    logic [WIDTH-1:0] fin_raw;
    logic [WIDTH-1:0] out_data_d;
    logic             out_ovf_d;

    assign fin_ctl = lv_ctl[LVL];
    assign fin_raw = lv_data[LVL];

    always_comb begin
        out_data_d = fin_raw;
        out_ovf_d  = 1'b0;
        if (fin_ctl.oor) begin
            if (fin_ctl.dir == SH_LEFT) begin
                out_ovf_d  = fin_ctl.xnz;
                out_data_d = (fin_ctl.xnz && SAT_EN) ? (fin_ctl.xsign ? SMIN : SMAX) : '0;
            end else begin
                out_data_d = RND_EN ? '0 : {WIDTH{fin_ctl.xsign}};
            end
        end else if (fin_ctl.dir == SH_LEFT) begin
            out_ovf_d = fin_ctl.ovf;
            if (fin_ctl.ovf && SAT_EN) begin
                out_data_d = fin_ctl.xsign ? SMIN : SMAX;
            end
        end else if (RND_EN) begin
            out_data_d = fin_raw + WIDTH'(fin_ctl.guard);
        end
    end

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_ovf_q;
    logic [TAGW-1:0]  out_tag_q;
    logic             out_load;

    assign out_load      = ~out_valid_q | out_ready;
    assign lv_ready[LVL] = out_load;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_tag_q   <= '0;
        end else if (out_load) begin
            out_valid_q <= lv_valid[LVL];
            if (lv_valid[LVL]) begin
                out_data_q <= out_data_d;
                out_ovf_q  <= out_ovf_d;
                out_tag_q  <= lv_tag[LVL];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_tag   = out_tag_q;

endmodule
